// File: rtl/parity_frame_checker.sv
// Accumulates parity over a valid/ready framed stream and reports one result per frame,
// with a saturating bad-frame counter. Define PARITY_FRAME_GEN_EN to add out_gen_parity.
module parity_frame_checker #(
  parameter int DATA_WIDTH      = 8,
  parameter int ODD_PARITY      = 0,
  parameter int MAX_FRAME_WORDS = 16,
  parameter int CNT_WIDTH       = 8,
  localparam int WW             = $clog2(MAX_FRAME_WORDS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  in_parity,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_parity_ok,
  output logic                  out_overrun,
  output logic [WW-1:0]         out_words,
`ifdef PARITY_FRAME_GEN_EN
  output logic                  out_gen_parity,
`endif
  output logic [CNT_WIDTH-1:0]  err_count,
  input  logic                  clr_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    REPORT  = 2'd2,
    DISCARD = 2'd3
  } state_t;

  localparam logic          ODD_BIT = (ODD_PARITY != 0);
  localparam logic [WW-1:0] MAX_CNT = WW'(MAX_FRAME_WORDS);

  function automatic logic word_parity(input logic [DATA_WIDTH-1:0] w);
    return ^w;
  endfunction

  state_t               state_q, state_d;
  logic                 acc_q, acc_d;
  logic [WW-1:0]        cnt_q, cnt_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 ok_q, ok_d;
  logic                 ovr_q, ovr_d;
  logic [WW-1:0]        words_q, words_d;
  logic                 gen_q, gen_d;
  logic [CNT_WIDTH-1:0] err_q, err_d;

  logic                 beat_s;
  logic                 acc_beat_s;
  logic [WW-1:0]        cnt_inc_s;
  logic                 handshake_s;

  assign beat_s      = in_valid & in_ready_q;
  assign acc_beat_s  = acc_q ^ word_parity(in_data);
  assign cnt_inc_s   = cnt_q + WW'(1);
  assign handshake_s = out_valid_q & out_ready;

  // Next-state, accumulator and result computation
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ok_d    = ok_q;
    ovr_d   = ovr_q;
    words_d = words_q;
    gen_d   = gen_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (beat_s) begin
          acc_d = word_parity(in_data);
          cnt_d = WW'(1);
          if (in_last) begin
            state_d = REPORT;
            ok_d    = ((word_parity(in_data) ^ in_parity) == ODD_BIT);
            ovr_d   = 1'b0;
            words_d = WW'(1);
            gen_d   = word_parity(in_data) ^ ODD_BIT;
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (beat_s) begin
          acc_d = acc_beat_s;
          cnt_d = cnt_inc_s;
          if (in_last) begin
            state_d = REPORT;
            ok_d    = ((acc_beat_s ^ in_parity) == ODD_BIT);
            ovr_d   = 1'b0;
            words_d = cnt_inc_s;
            gen_d   = acc_beat_s ^ ODD_BIT;
          end else if (cnt_inc_s == MAX_CNT) begin
            // Frame cut at the limit: in_parity on this beat is meaningless
            state_d = REPORT;
            ok_d    = 1'b0;
            ovr_d   = 1'b1;
            words_d = cnt_inc_s;
            gen_d   = acc_beat_s ^ ODD_BIT;
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = ACCUM;
        end
      end
      REPORT: begin
        if (out_ready) begin
          state_d = ovr_q ? DISCARD : IDLE;
          acc_d   = 1'b0;
          cnt_d   = {WW{1'b0}};
          if (!ok_q && (err_q != {CNT_WIDTH{1'b1}})) begin
            err_d = err_q + CNT_WIDTH'(1);
          end else begin
            err_d = err_q;
          end
        end else begin
          state_d = REPORT;
        end
      end
      DISCARD: begin
        if (beat_s && in_last) begin
          state_d = IDLE;
        end else begin
          state_d = DISCARD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (clr_count) begin
      err_d = {CNT_WIDTH{1'b0}};
    end else begin
      err_d = err_d;
    end

    in_ready_d  = (state_d != REPORT);
    out_valid_d = (state_d == REPORT);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= 1'b0;
      cnt_q       <= {WW{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      ok_q        <= 1'b0;
      ovr_q       <= 1'b0;
      words_q     <= {WW{1'b0}};
      gen_q       <= 1'b0;
      err_q       <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      ok_q        <= ok_d;
      ovr_q       <= ovr_d;
      words_q     <= words_d;
      gen_q       <= gen_d;
      err_q       <= err_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_parity_ok = ok_q;
  assign out_overrun   = ovr_q;
  assign out_words     = words_q;
  assign err_count     = err_q;
`ifdef PARITY_FRAME_GEN_EN
  assign out_gen_parity = gen_q;
`else
  logic unused_gen_s;
  assign unused_gen_s = gen_q;
`endif

endmodule

// File: tb/tb_parity_frame_checker.sv
// Drives an even-parity and an odd-parity instance (MAX_FRAME_WORDS=4, CNT_WIDTH=2) with
// identical streams and checks both against a frame-level reference model.
module tb_parity_frame_checker;

  localparam int MAXW   = 4;
  localparam int ERRMAX = 3;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_last, in_parity, out_ready, clr_count;
  logic [7:0] in_data;

  logic       in_ready0, out_valid0, ok0, ovr0, gen0;
  logic [2:0] words0;
  logic [1:0] err0;
  logic       in_ready1, out_valid1, ok1, ovr1, gen1;
  logic [2:0] words1;
  logic [1:0] err1;

  int checks   = 0;
  int failures = 0;
  int m_err0   = 0;
  int m_err1   = 0;
  logic [7:0] fq[$];

  always #5 clk = ~clk;

  parity_frame_checker #(.DATA_WIDTH(8), .ODD_PARITY(0), .MAX_FRAME_WORDS(MAXW), .CNT_WIDTH(2)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .in_last(in_last), .in_parity(in_parity), .out_valid(out_valid0), .out_ready(out_ready),
    .out_parity_ok(ok0), .out_overrun(ovr0), .out_words(words0),
`ifdef PARITY_FRAME_GEN_EN
    .out_gen_parity(gen0),
`endif
    .err_count(err0), .clr_count(clr_count));

  parity_frame_checker #(.DATA_WIDTH(8), .ODD_PARITY(1), .MAX_FRAME_WORDS(MAXW), .CNT_WIDTH(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .in_last(in_last), .in_parity(in_parity), .out_valid(out_valid1), .out_ready(out_ready),
    .out_parity_ok(ok1), .out_overrun(ovr1), .out_words(words1),
`ifdef PARITY_FRAME_GEN_EN
    .out_gen_parity(gen1),
`endif
    .err_count(err1), .clr_count(clr_count));

`ifndef PARITY_FRAME_GEN_EN
  assign gen0 = 1'b0;
  assign gen1 = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one beat and wait (bounded) for it to be accepted; returns at the following negedge.
  task automatic drive_beat(input logic [7:0] d, input logic l, input logic p);
    bit done = 0;
    in_valid = 1'b1; in_data = d; in_last = l; in_parity = p;
    for (int t = 0; t < 20 && !done; t++) begin
      if (in_ready0 === 1'b1) begin
        @(posedge clk);
        done = 1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (!done) chk("beat_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_report(input bit ovr, input int counted, input int ones, input logic par,
                              input int hold, input bit clr_hs);
    bit e_ok0, e_ok1;
    e_ok0 = !ovr && ((ones + par) % 2 == 0);
    e_ok1 = !ovr && ((ones + par) % 2 == 1);
    chk("out_valid0", out_valid0, 1); chk("out_valid1", out_valid1, 1);
    chk("in_ready_report", in_ready0, 0);
    chk("ok_even", ok0, e_ok0); chk("ok_odd", ok1, e_ok1);
    chk("overrun0", ovr0, ovr); chk("overrun1", ovr1, ovr);
    chk("words0", words0, counted); chk("words1", words1, counted);
`ifdef PARITY_FRAME_GEN_EN
    chk("gen_even", gen0, ones % 2); chk("gen_odd", gen1, (ones + 1) % 2);
`endif
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_valid", out_valid0, 1); chk("hold_ready", in_ready0, 0);
      chk("hold_ok", ok0, e_ok0); chk("hold_words", words0, counted);
      chk("hold_err0", err0, m_err0); chk("hold_err1", err1, m_err1);
    end
    out_ready = 1'b1; clr_count = clr_hs;
    @(negedge clk);
    out_ready = 1'b0; clr_count = 1'b0;
    if (clr_hs) begin m_err0 = 0; m_err1 = 0; end
    else begin
      if (!e_ok0 && m_err0 < ERRMAX) m_err0++;
      if (!e_ok1 && m_err1 < ERRMAX) m_err1++;
    end
    chk("err0", err0, m_err0); chk("err1", err1, m_err1);
    chk("valid_after_hs", out_valid0, 0);
  endtask

  // Send the n words in fq; last on word n; report expected after min(n, MAXW) words.
  task automatic send_frame(input int n, input logic par, input int hold, input bit clr_hs);
    bit ovr;
    int counted, ones;
    ovr = (n > MAXW);
    counted = ovr ? MAXW : n;
    ones = 0;
    for (int i = 0; i < n; i++) begin
      drive_beat(fq[i], (i == n - 1), (i == n - 1) ? par : 1'($urandom));
      if (i < counted) ones += $countones(fq[i]);
      if (i == counted - 1) check_report(ovr, counted, ones, par, hold, clr_hs);
    end
    if (ovr) begin
      chk("no_second_report", out_valid0, 0);
      chk("idle_after_discard", in_ready0, 1);
    end
  endtask

  task automatic fill_random(input int n);
    fq.delete();
    for (int i = 0; i < n; i++) fq.push_back(8'($urandom));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; in_parity = 1'b0;
    out_ready = 1'b0; clr_count = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready0, 1); chk("rst_out_valid", out_valid0, 0);
    chk("rst_ok", ok0, 0); chk("rst_ovr", ovr0, 0);
    chk("rst_words", words0, 0); chk("rst_err", err0, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1-word zero frame, even parity good
    fq.delete(); fq.push_back(8'h00);
    send_frame(1, 1'b0, 0, 0);
    // 3-word frame with seven ones, wrong then right parity for even mode
    fq.delete(); fq.push_back(8'h01); fq.push_back(8'hF0); fq.push_back(8'h03);
    send_frame(3, 1'b0, 0, 0);
    send_frame(3, 1'b1, 0, 0);
    // Single 8'h01 with both parity bits
    fq.delete(); fq.push_back(8'h01);
    send_frame(1, 1'b0, 0, 0);
    send_frame(1, 1'b1, 0, 0);
    // Backpressure for 5 cycles on a bad frame
    fq.delete(); fq.push_back(8'h07); fq.push_back(8'h10);
    send_frame(2, 1'b1, 5, 0);
    // Exactly MAXW words with in_last is not an overrun
    fill_random(MAXW);
    send_frame(MAXW, 1'b0, 1, 0);
    // Overrun: six words, then a normal frame
    fill_random(6);
    send_frame(6, 1'b1, 2, 0);
    fq.delete(); fq.push_back(8'h03);
    send_frame(1, 1'b0, 0, 0);
    // Saturation via overrun frames (bad in both modes)
    for (int f = 0; f < 5; f++) begin
      fill_random(5);
      send_frame(5, 1'b0, 0, 0);
    end
    chk("sat_err0", err0, ERRMAX); chk("sat_err1", err1, ERRMAX);
    // Clear coinciding with a bad-frame handshake
    fill_random(5);
    send_frame(5, 1'b0, 0, 1);
    chk("clr_hs_err0", err0, 0);

    // Reset mid-frame drops the partial frame
    fill_random(3);
    drive_beat(fq[0], 1'b0, 1'b0);
    drive_beat(fq[1], 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; m_err0 = 0; m_err1 = 0;
    chk("mid_rst_valid", out_valid0, 0); chk("mid_rst_ready", in_ready0, 1);
    chk("mid_rst_ok", ok0, 0); chk("mid_rst_ovr", ovr0, 0);
    chk("mid_rst_words", words0, 0); chk("mid_rst_err", err0, 0);
    repeat (2) @(negedge clk);
    chk("mid_rst_no_report", out_valid0, 0);

    // Randomized frames, including overruns, backpressure and occasional clears
    for (int f = 0; f < 40; f++) begin
      int n;
      n = $urandom_range(1, 6);
      fill_random(n);
      send_frame(n, 1'($urandom), $urandom_range(0, 2), ($urandom_range(0, 7) == 0));
    end

    // Standalone clear
    clr_count = 1'b1;
    @(negedge clk);
    clr_count = 1'b0; m_err0 = 0; m_err1 = 0;
    chk("clr_err0", err0, 0); chk("clr_err1", err1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parity_frame_checker.md
Name: parity_frame_checker

Overview:
- Sequential, parametrised successor to the single-word combinational parity checker.
- Accumulates parity over a multi-word frame delivered on a valid/ready stream, then compares it with the parity bit sent alongside the last word.
- Reports one result per frame through an output handshake and keeps a saturating error counter.
- Sits between a byte/word receiver and the link-status logic.

Parameters:
- DATA_WIDTH, 8: bits per input word.
- ODD_PARITY, 0: 0 = even parity (XOR of all frame bits plus parity bit must be 0); 1 = odd parity (must be 1).
- MAX_FRAME_WORDS, 16: frame length limit; a frame reaching this count without in_last is an overrun. Must be ≥ 2.
- CNT_WIDTH, 8: width of the error counter.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  block accepts a word this cycle.
- in_data  input  DATA_WIDTH  frame word.
- in_last  input  1  marks the final word of the frame.
- in_parity  input  1  received parity bit; sampled only on an accepted beat with in_last=1.
- out_valid  output  1  frame result available.
- out_ready  input  1  consumer takes the result.
- out_parity_ok  output  1  1 = frame parity correct.
- out_overrun  output  1  1 = frame was cut at MAX_FRAME_WORDS.
- out_words  output  $clog2(MAX_FRAME_WORDS+1)  words counted in the reported frame.
- err_count  output  CNT_WIDTH  saturating count of bad frames.
- clr_count  input  1  synchronous clear of err_count.

Behaviour:
- One clock; reset is synchronous and active-high; ports are named clk and rst.
- Reset values: state = IDLE; in_ready = 1; out_valid = 0; out_parity_ok = 0; out_overrun = 0; out_words = 0; err_count = 0; accumulator = 0; word counter = 0. A reset mid-frame discards the partial frame with no report.
- Beat accepted = in_valid & in_ready.
- States:
  - IDLE: in_ready = 1. Any accepted beat loads acc = ^in_data and cnt = 1.
    - With in_last → REPORT.
    - Without in_last → ACCUM.
  - ACCUM: in_ready = 1. On each accepted beat, acc ^= ^in_data and cnt++.
    - in_last → REPORT.
    - cnt reaches MAX_FRAME_WORDS without in_last → REPORT with overrun, then DISCARD after handshake.
  - REPORT: in_ready = 0; out_valid = 1; outputs held stable until out_ready.
    - On out_valid & out_ready → IDLE, or → DISCARD if overrun.
  - DISCARD: in_ready = 1. Accepted beats are dropped and not counted. An accepted beat with in_last → IDLE.
- Result (registered on entry to REPORT):
  - out_parity_ok = ((acc ^ in_parity) == ODD_PARITY), and 0 on overrun.
  - out_overrun = overrun flag.
  - out_words = cnt including the final beat.
- Latency: out_valid rises the cycle after the accepted last beat. Minimum frame period is 2 cycles (1-word frame with out_ready held high).
- err_count:
  - Increments by 1 on the REPORT handshake when out_parity_ok = 0.
  - Saturates at 2^CNT_WIDTH−1.
  - clr_count has priority over a simultaneous increment: result is 0.
- in_parity is ignored on non-last beats and on overrun beats.
- in_valid low in any state holds state; no timeout.

Optional Feature:
- Macro PARITY_FRAME_GEN_EN.
- When defined:
  - Adds output out_gen_parity (1 bit), registered with the other results.
  - Value is the parity bit that would make the frame valid: acc ^ ODD_PARITY.
  - It is valid with out_valid, including on overrun (computed over the counted words).
- When undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- Even mode, 1-word frame 8'h00 with in_parity=0, out_ready=1 → next cycle out_valid=1, out_parity_ok=1, out_words=1, err_count=0.
- Even mode, 3-word frame 8'h01, 8'hF0, 8'h03 (total ones = 7), in_parity=0 → out_parity_ok=0, out_words=3, err_count=1. Repeat with in_parity=1 → ok=1, err_count stays 1.
- ODD_PARITY=1, frame 8'h01 with in_parity=0 → ok=1. Same frame with in_parity=1 → ok=0.
- Backpressure: hold out_ready=0 for 5 cycles after the result → in_ready=0, outputs stable throughout, err_count updates only on the handshake cycle.
- Overrun with MAX_FRAME_WORDS=4: send 6 words with in_last on the 6th → report after word 4 with out_overrun=1, ok=0, out_words=4. Words 5–6 are discarded with no second report; the next frame reports normally.
- CNT_WIDTH=2: five bad frames → err_count reaches 3 and holds. clr_count asserted on the same cycle as a bad-frame handshake → err_count=0. rst asserted mid-frame → no report, all outputs return to reset values.
